mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port 16-bit unified memory between the instruction-fetch path and the data-load/store path of the multicycle processor. It sits between the two requesters (fetch side feeding the instruction register, data side feeding the memory data register) and the memory array. It serialises accesses, inserts a configurable number of wait states, and pulses a one-cycle acknowledge with registered read data. Data accesses have priority; a streak counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one single-port memory,
// data first, with a grant-streak limit that guarantees fetch forward progress.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_ack,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [1:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d, cnt_q, cnt_d;
    logic        dm_own_q, dm_own_d, we_q, we_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic        grant_dm;

    // Data wins unless a waiting fetch has already been passed over MAX_STREAK times.
    assign grant_dm = dm_req && !(if_req && streak_q >= STREAK_MAX);

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cnt_d      = cnt_q;
        dm_own_d   = dm_own_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: if (if_req || dm_req) begin
                state_d  = ACCESS;
                dm_own_d = grant_dm;
                we_d     = grant_dm && dm_we;
                addr_d   = grant_dm ? dm_addr : if_addr;
                wdata_d  = grant_dm ? dm_wdata : wdata_q;
                cnt_d    = WAIT_INIT;
                streak_d = (grant_dm && if_req) ? streak_q + 4'd1 : 4'd0;
            end
            ACCESS: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d    = RESP;
                dm_rdata_d = (dm_own_q && !we_q) ? mem_rdata : dm_rdata_q;
                if_rdata_d = !dm_own_q ? mem_rdata : if_rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            streak_q   <= 4'd0;
            cnt_q      <= 4'd0;
            dm_own_q   <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            if_rdata_q <= 16'h0000;
            dm_rdata_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cnt_q      <= cnt_d;
            dm_own_q   <= dm_own_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en    = state_q == ACCESS;
    assign mem_we    = mem_en && cnt_q == 4'd0 && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = state_q == RESP && !dm_own_q;
    assign dm_ack    = state_q == RESP && dm_own_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; expected acks (owner, cycle, data) are queued
// as requests are issued and retired when the arbiter acknowledges.
module tb_mem_port_arbiter;
    localparam int WC = 2;
    localparam int MS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        if_req, if_ack, dm_req, dm_we, dm_ack, mem_en, mem_we, busy;
    logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        w0_if_req, w0_if_ack, w0_dm_ack, w0_mem_en, w0_mem_we, w0_busy;
    logic [15:0] w0_if_addr, w0_if_rdata, w0_dm_rdata, w0_mem_addr, w0_mem_wdata, w0_mem_rdata;

    mem_port_arbiter #(.WAIT_CYCLES(WC), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0), .MAX_STREAK(4)) dut_w0 (
        .clk(clk), .rst(rst),
        .if_req(w0_if_req), .if_addr(w0_if_addr), .if_ack(w0_if_ack), .if_rdata(w0_if_rdata),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(16'h0000),
        .dm_ack(w0_dm_ack), .dm_rdata(w0_dm_rdata),
        .mem_en(w0_mem_en), .mem_we(w0_mem_we), .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata),
        .mem_rdata(w0_mem_rdata), .busy(w0_busy)
    );

    function automatic logic [15:0] init_val(int a);
        if (a == 'h0010) return 16'hA5A5;
        if (a == 'h0100) return 16'h1234;
        if (a == 'h0050) return 16'h7777;
        return 16'(a * 257) ^ 16'h5A5A;
    endfunction

    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata    = mem[mem_addr];
    assign w0_mem_rdata = mem[w0_mem_addr];

    int errors = 0;
    int checks = 0;
    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct { logic dm; logic [15:0] data; int cyc; } exp_t;
    exp_t sb[$];
    exp_t sb0[$];
    exp_t e, e0;
    logic [15:0] dm_rd_model = 16'h0000;

    task automatic push(logic dm, logic [15:0] d, int c);
        exp_t x;
        x.dm = dm; x.data = d; x.cyc = c;
        sb.push_back(x);
    endtask

    always @(negedge clk) if (!rst && (if_ack || dm_ack)) begin
        check_eq("ack_excl", 32'(if_ack & dm_ack), 32'd0);
        if (sb.size() == 0) check_eq("spurious_ack", 32'(dm_ack), 32'(if_ack));
        else begin
            e = sb.pop_front();
            check_eq("ack_owner", 32'(dm_ack), 32'(e.dm));
            check_eq("ack_cycle", 32'(cyc), 32'(e.cyc));
            check_eq("ack_rdata", 32'(dm_ack ? dm_rdata : if_rdata), 32'(e.data));
        end
    end

    always @(negedge clk) if (!rst) begin
        if (w0_mem_en) check_eq("w0_no_we", 32'(w0_mem_we), 32'd0);
        if (w0_if_ack || w0_dm_ack) begin
            check_eq("w0_owner", 32'(w0_dm_ack), 32'd0);
            if (sb0.size() == 0) check_eq("w0_spurious_ack", 32'd1, 32'd0);
            else begin
                e0 = sb0.pop_front();
                check_eq("w0_ack_cycle", 32'(cyc), 32'(e0.cyc));
                check_eq("w0_rdata", 32'(w0_if_rdata), 32'(e0.data));
            end
        end
    end

    task automatic wait_ack(int sel);
        int t = 0;
        logic a;
        do begin
            @(negedge clk);
            a = sel == 0 ? if_ack : sel == 1 ? dm_ack : w0_if_ack;
            t++;
        end while (!a && t < 64);
        if (!a) check_eq($sformatf("ack_timeout_%0d", sel), 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_txn(logic [15:0] a, int n);
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < n; i++) wait_ack(0);
        if_req = 1'b0;
    endtask

    task automatic data_txn(logic we, logic [15:0] a, logic [15:0] wd, int n);
        dm_we    = we;
        dm_wdata = wd;
        dm_req   = 1'b1;
        for (int i = 0; i < n; i++) begin
            dm_addr = a + 16'(i);
            wait_ack(1);
        end
        dm_req = 1'b0;
    endtask

    // Cycle k of an access started in cycle T is sampled at the negedge of T+k.
    task automatic timeline(logic [15:0] addr, logic store);
        for (int k = 0; k <= WC + 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("mem_en@%0d", k), 32'(mem_en), 32'(k >= 1 && k <= WC + 1));
            check_eq($sformatf("mem_we@%0d", k), 32'(mem_we), 32'(store && k == WC + 1));
            check_eq($sformatf("busy@%0d", k), 32'(busy), 32'(k >= 1 && k <= WC + 2));
            if (k >= 1 && k <= WC + 1) check_eq($sformatf("mem_addr@%0d", k), 32'(mem_addr), 32'(addr));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int t0;
    initial begin
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        w0_if_req = 0; w0_if_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_if_ack", 32'(if_ack), 32'd0);
        check_eq("rst_dm_ack", 32'(dm_ack), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_if_rdata", 32'(if_rdata), 32'd0);
        check_eq("rst_dm_rdata", 32'(dm_rdata), 32'd0);
        check_eq("rst_w0_busy", 32'(w0_busy), 32'd0);
        check_eq("rst_w0_dm_rdata", 32'(w0_dm_rdata), 32'd0);
        check_eq("rst_w0_mem_wdata", 32'(w0_mem_wdata), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        t0 = cyc;
        push(1'b0, 16'hA5A5, t0 + 2 + WC);
        fork
            fetch_txn(16'h0010, 1);
            timeline(16'h0010, 1'b0);
        join

        t0 = cyc;
        dm_rd_model = 16'h1234;
        push(1'b1, 16'h1234, t0 + 2 + WC);
        push(1'b0, init_val('h0020), t0 + 5 + 2 * WC);
        fork
            fetch_txn(16'h0020, 1);
            data_txn(1'b0, 16'h0100, 16'h0000, 1);
        join

        t0 = cyc;
        push(1'b1, dm_rd_model, t0 + 2 + WC);
        fork
            data_txn(1'b1, 16'h0042, 16'hBEEF, 1);
            timeline(16'h0042, 1'b1);
        join
        check_eq("store_mem", 32'(mem['h0042]), 32'hBEEF);

        // With MAX_STREAK=2 and both sides always requesting: D, D, F, D, D, F.
        t0 = cyc;
        push(1'b1, init_val('h0200), t0 + 2 + WC);
        push(1'b1, init_val('h0201), t0 + 2 + WC + (WC + 3));
        push(1'b0, init_val('h0030), t0 + 2 + WC + 2 * (WC + 3));
        push(1'b1, init_val('h0202), t0 + 2 + WC + 3 * (WC + 3));
        push(1'b1, init_val('h0203), t0 + 2 + WC + 4 * (WC + 3));
        push(1'b0, init_val('h0030), t0 + 2 + WC + 5 * (WC + 3));
        dm_rd_model = init_val('h0203);
        fork
            fetch_txn(16'h0030, 2);
            data_txn(1'b0, 16'h0200, 16'h0000, 4);
        join

        dm_we = 1'b1; dm_addr = 16'h0050; dm_wdata = 16'h1111; dm_req = 1'b1;
        @(posedge clk); #1;
        check_eq("pre_rst_mem_en", 32'(mem_en), 32'd1);
        rst = 1'b1; dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_mid_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mid_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < WC + 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("rst_no_ack@%0d", k), 32'(dm_ack | if_ack), 32'd0);
        end
        check_eq("rst_mem_kept", 32'(mem['h0050]), 32'h7777);

        @(posedge clk); #1;
        t0 = cyc;
        begin
            exp_t x;
            x.dm = 1'b0; x.data = init_val(0); x.cyc = t0 + 2; sb0.push_back(x);
            x.data = init_val(1); x.cyc = t0 + 5; sb0.push_back(x);
        end
        w0_if_addr = 16'h0000; w0_if_req = 1'b1;
        wait_ack(2);
        w0_if_addr = 16'h0001;
        wait_ack(2);
        w0_if_req = 1'b0;

        repeat (4) @(negedge clk);
        check_eq("sb_drained", 32'(sb.size() + sb0.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
